// File: rtl/ten_gig_link_ctrl.sv
// rtl/ten_gig_link_ctrl.sv - 10GBASE-R PCS/PMA bring-up and recovery sequencer
module ten_gig_link_ctrl #(
    parameter int RST_PULSE_CYC = 16,
    parameter int DONE_TIMEOUT  = 2000000,
    parameter int SYNC_TIMEOUT  = 2000000,
    parameter int STABLE_CYC    = 65536,
    parameter int MAX_RETRY     = 8
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic       i_rst_done,
    input  logic       i_block_sync,
    input  logic       i_pcs_rx_link,
    output logic       o_pcspma_rst,
    output logic       o_link_up,
    output logic       o_link_drop,
    output logic       o_fail,
    output logic [2:0] o_state,
    output logic [7:0] o_retry_cnt
);

    localparam int MAX_DS  = (DONE_TIMEOUT > SYNC_TIMEOUT) ? DONE_TIMEOUT : SYNC_TIMEOUT;
    localparam int CNT_MAX = (MAX_DS > STABLE_CYC) ? MAX_DS : STABLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        WAIT_DONE = 3'd2,
        WAIT_SYNC = 3'd3,
        QUALIFY   = 3'd4,
        UP        = 3'd5,
        FAIL      = 3'd6
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [7:0]         retry, retry_next, retry_inc;
    logic               drop_next;
    logic               take_retry;
    logic [2:0]         sync1, sync2;
    logic               s_rst_done, s_block_sync, s_pcs_rx_link, s_linked;

    // Two-stage synchronizers for the coreclk status bits
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= {i_rst_done, i_block_sync, i_pcs_rx_link};
            sync2 <= sync1;
        end
    end

    assign s_rst_done    = sync2[2];
    assign s_block_sync  = sync2[1];
    assign s_pcs_rx_link = sync2[0];
    assign s_linked      = s_block_sync & s_pcs_rx_link;
    assign retry_inc     = (retry == 8'hFF) ? 8'hFF : retry + 8'd1;

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        retry_next = retry;
        drop_next  = 1'b0;
        take_retry = 1'b0;
        if (!i_enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = RESET;
                    retry_next = 8'd0;
                end
                RESET:
                    if (cnt == CNT_W'(RST_PULSE_CYC - 1)) state_next = WAIT_DONE;
                WAIT_DONE:
                    if (s_rst_done) state_next = WAIT_SYNC;
                    else if (cnt == CNT_W'(DONE_TIMEOUT - 1)) take_retry = 1'b1;
                WAIT_SYNC:
                    if (s_linked) state_next = QUALIFY;
                    else if (cnt == CNT_W'(SYNC_TIMEOUT - 1)) take_retry = 1'b1;
                QUALIFY:
                    if (!s_linked) state_next = WAIT_SYNC;
                    else if (cnt == CNT_W'(STABLE_CYC - 1)) state_next = UP;
                UP:
                    if (!(s_linked && s_rst_done)) begin
                        state_next = RESET;
                        drop_next  = 1'b1;
                        retry_next = 8'd0;
                    end
                FAIL:    state_next = FAIL;
                default: state_next = IDLE;
            endcase
        end
        // Success checks above run first, so a condition met on the last window cycle wins
        if (take_retry) begin
            retry_next = retry_inc;
            if (MAX_RETRY != 0 && int'(retry_inc) >= MAX_RETRY) state_next = FAIL;
            else state_next = RESET;
        end
        if (state_next != state) cnt_next = '0;
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            retry        <= 8'd0;
            o_pcspma_rst <= 1'b1;
            o_link_up    <= 1'b0;
            o_link_drop  <= 1'b0;
            o_fail       <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            retry        <= retry_next;
            o_pcspma_rst <= (state_next == IDLE) || (state_next == RESET) || (state_next == FAIL);
            o_link_up    <= (state_next == UP);
            o_link_drop  <= drop_next;
            o_fail       <= (state_next == FAIL);
        end
    end

    assign o_state     = state;
    assign o_retry_cnt = retry;

endmodule

// File: tb/tb_ten_gig_link_ctrl.sv
// tb/tb_ten_gig_link_ctrl.sv - scoreboard bench for ten_gig_link_ctrl
module tb_ten_gig_link_ctrl;

    localparam int RP  = 16;
    localparam int DT  = 300;
    localparam int STO = 200;
    localparam int SC  = 64;
    localparam int MR  = 3;

    localparam int S_IDLE = 0, S_RESET = 1, S_WDONE = 2, S_WSYNC = 3, S_QUAL = 4, S_UP = 5, S_FAIL = 6;

    typedef struct packed {
        logic [2:0] st;
        logic       prst;
        logic       up;
        logic       drop;
        logic       fail;
        logic [7:0] retry;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, rd = 1'b0, bs = 1'b0, lk = 1'b0;
    logic rst0 = 1'b1, en0 = 1'b1, zero = 1'b0;
    logic       o_pcspma_rst, o_link_up, o_link_drop, o_fail;
    logic [2:0] o_state;
    logic [7:0] o_retry_cnt;
    logic       f_prst, f_up, f_drop, f_fail;
    logic [2:0] f_state;
    logic [7:0] f_retry;

    int   tests = 0, failed = 0, cycles = 0;
    exp_t exp_q[$];
    logic [2:0] hist[$];
    int   m_state, m_cnt, m_retry;
    bit   saw_fail0 = 0;

    always #5 clk = ~clk;

    ten_gig_link_ctrl #(
        .RST_PULSE_CYC(RP), .DONE_TIMEOUT(DT), .SYNC_TIMEOUT(STO), .STABLE_CYC(SC), .MAX_RETRY(MR)
    ) dut (
        .i_sys_clk(clk), .i_rst(rst), .i_enable(en), .i_rst_done(rd), .i_block_sync(bs),
        .i_pcs_rx_link(lk), .o_pcspma_rst(o_pcspma_rst), .o_link_up(o_link_up),
        .o_link_drop(o_link_drop), .o_fail(o_fail), .o_state(o_state), .o_retry_cnt(o_retry_cnt)
    );

    ten_gig_link_ctrl #(
        .RST_PULSE_CYC(4), .DONE_TIMEOUT(20), .SYNC_TIMEOUT(20), .STABLE_CYC(4), .MAX_RETRY(0)
    ) dut_forever (
        .i_sys_clk(clk), .i_rst(rst0), .i_enable(en0), .i_rst_done(zero), .i_block_sync(zero),
        .i_pcs_rx_link(zero), .o_pcspma_rst(f_prst), .o_link_up(f_up),
        .o_link_drop(f_drop), .o_fail(f_fail), .o_state(f_state), .o_retry_cnt(f_retry)
    );

    function automatic int attempt_failed();
        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
        return (MR != 0 && m_retry >= MR) ? S_FAIL : S_RESET;
    endfunction

    // Reference: status inputs reach the sequencer two clocks late; decisions follow the bring-up rules
    task automatic model_loop();
        logic [2:0] s;
        int nst;
        bit drop_e;
        forever begin
            @(posedge clk);
            cycles++;
            drop_e = 0;
            if (rst) begin
                m_state = S_IDLE; m_cnt = 0; m_retry = 0;
                hist = '{3'b000, 3'b000};
                nst = S_IDLE;
            end else begin
                s = hist.pop_front();
                hist.push_back({rd, bs, lk});
                nst = m_state;
                if (!en) nst = S_IDLE;
                else case (m_state)
                    S_IDLE:  begin nst = S_RESET; m_retry = 0; end
                    S_RESET: if (m_cnt == RP - 1) nst = S_WDONE;
                    S_WDONE: if (s[2]) nst = S_WSYNC;
                             else if (m_cnt == DT - 1) nst = attempt_failed();
                    S_WSYNC: if (s[1] && s[0]) nst = S_QUAL;
                             else if (m_cnt == STO - 1) nst = attempt_failed();
                    S_QUAL:  if (!(s[1] && s[0])) nst = S_WSYNC;
                             else if (m_cnt == SC - 1) nst = S_UP;
                    S_UP:    if (!(s[2] && s[1] && s[0])) begin
                                 nst = S_RESET; drop_e = 1; m_retry = 0;
                             end
                    default: ;
                endcase
                m_cnt = (nst != m_state) ? 0 : m_cnt + 1;
                m_state = nst;
            end
            exp_q.push_back('{st: 3'(nst),
                              prst: (nst == S_IDLE || nst == S_RESET || nst == S_FAIL),
                              up: (nst == S_UP), drop: drop_e, fail: (nst == S_FAIL),
                              retry: 8'(m_retry)});
        end
    endtask

    task automatic monitor_loop();
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (!rst0 && f_fail) saw_fail0 = 1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{st: o_state, prst: o_pcspma_rst, up: o_link_up, drop: o_link_drop,
                      fail: o_fail, retry: o_retry_cnt};
                tests++;
                if (a !== e) begin
                    failed++;
                    if (failed <= 20)
                        $display("FAIL scoreboard @%0t: got st=%0d rst=%0b up=%0b drop=%0b fail=%0b retry=%0d, expected st=%0d rst=%0b up=%0b drop=%0b fail=%0b retry=%0d",
                                 $time, a.st, a.prst, a.up, a.drop, a.fail, a.retry,
                                 e.st, e.prst, e.up, e.drop, e.fail, e.retry);
                end
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        fork
            model_loop();
            monitor_loop();
        join_none
        cyc(3);
        rst = 1'b0; rst0 = 1'b0;
        check("reset_state", int'(o_state), S_IDLE);
        check("reset_pcspma_rst", int'(o_pcspma_rst), 1);

        en = 1'b1; cyc(100); rd = 1'b1; cyc(100); bs = 1'b1; lk = 1'b1; cyc(SC + 40);
        check("bringup_up", int'(o_link_up), 1);
        check("bringup_retry", int'(o_retry_cnt), 0);

        lk = 1'b0; cyc(5); lk = 1'b1; cyc(RP + SC + 40);
        check("relink_up", int'(o_link_up), 1);

        bs = 1'b0; cyc(RP + 10); bs = 1'b1; cyc(20);
        check("glitch_in_qualify", int'(o_state), S_QUAL);
        bs = 1'b0; cyc(1); bs = 1'b1; cyc(SC + 40);
        check("glitch_then_up", int'(o_link_up), 1);

        bs = 1'b0; cyc(3 * (RP + STO + 10));
        check("sync_timeout_fail", int'(o_fail), 1);
        check("sync_timeout_retry", int'(o_retry_cnt), MR);

        en = 1'b0; cyc(1);
        check("fail_disable_state", int'(o_state), S_IDLE);
        check("fail_disable_fail", int'(o_fail), 0);

        rd = 1'b0; lk = 1'b0; en = 1'b1; cyc(3 * (RP + DT) + 20);
        check("done_timeout_fail", int'(o_fail), 1);
        check("done_timeout_retry", int'(o_retry_cnt), MR);
        en = 1'b0; cyc(2);

        rd = 1'b1; en = 1'b1; cyc(RP + 20);
        check("wait_sync_state", int'(o_state), S_WSYNC);
        en = 1'b0; cyc(1);
        check("wait_sync_disable", int'(o_state), S_IDLE);
        check("wait_sync_disable_rst", int'(o_pcspma_rst), 1);

        en = 1'b1; bs = 1'b1; lk = 1'b1; cyc(RP + SC + 40);
        check("pre_rst_up", int'(o_link_up), 1);
        rst = 1'b1; cyc(1); rst = 1'b0;
        check("midrun_rst_state", int'(o_state), S_IDLE);
        check("midrun_rst_up", int'(o_link_up), 0);
        check("midrun_rst_prst", int'(o_pcspma_rst), 1);

        for (int seg = 0; seg < 70; seg++) begin
            int len;
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : $urandom_range(20, 260);
            rd = ($urandom_range(0, 7) != 0);
            bs = ($urandom_range(0, 3) != 0);
            lk = ($urandom_range(0, 3) != 0);
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 31) == 0) begin rst = 1'b1; cyc(1); rst = 1'b0; end
            cyc(len);
        end

        while (cycles < 7000) cyc(1);
        check("forever_never_fail", int'(saw_fail0), 0);
        check("forever_retry_saturates", int'(f_retry), 255);
        check("scoreboard_active", int'(tests > 1000), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
